// File: rtl/network_rx_return_queue.sv
// Return-path queue: pairs captured request metadata with the next-cycle response
// word and injects the result into the return network via valid/ready.
module network_rx_return_queue #(
  parameter int unsigned data_width_p   = 32,
  parameter int unsigned x_cord_width_p = 7,
  parameter int unsigned y_cord_width_p = 7,
  parameter int unsigned reg_id_width_p = 5,
  parameter int unsigned els_p          = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      req_yumi_i,
  input  logic [x_cord_width_p-1:0] req_src_x_i,
  input  logic [y_cord_width_p-1:0] req_src_y_i,
  input  logic [reg_id_width_p-1:0] req_reg_id_i,
  input  logic                      req_w_i,
  input  logic                      req_float_wb_i,
  input  logic                      rsp_v_i,
  input  logic [data_width_p-1:0]   rsp_data_i,
  output logic                      credit_avail_o,
  output logic                      ret_v_o,
  output logic [1:0]                ret_type_o,
  output logic [data_width_p-1:0]   ret_data_o,
  output logic [reg_id_width_p-1:0] ret_reg_id_o,
  output logic [x_cord_width_p-1:0] ret_x_o,
  output logic [y_cord_width_p-1:0] ret_y_o,
  input  logic                      ret_ready_i
);

  localparam int unsigned PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned CNT_W = $clog2(els_p + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  localparam logic [1:0] TYPE_CREDIT   = 2'd0;
  localparam logic [1:0] TYPE_INT_WB   = 2'd1;
  localparam logic [1:0] TYPE_FLOAT_WB = 2'd2;

  typedef struct packed {
    logic [x_cord_width_p-1:0] x;
    logic [y_cord_width_p-1:0] y;
    logic [reg_id_width_p-1:0] reg_id;
    logic [1:0]                typ;
  } meta_t;

  typedef struct packed {
    meta_t                   meta;
    logic [data_width_p-1:0] data;
  } entry_t;

  logic             r_pending;
  meta_t            r_meta;
  entry_t           r_mem [els_p];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_enq;
  logic             w_deq;
  logic             w_full;
  logic             w_push;
  logic [1:0]       w_req_type;
  logic [OCC_W-1:0] w_occ;
  entry_t           w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(els_p - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_req_type = req_w_i ? TYPE_CREDIT : (req_float_wb_i ? TYPE_FLOAT_WB : TYPE_INT_WB);
  assign w_enq      = rsp_v_i & r_pending;
  assign w_deq      = ret_v_o & ret_ready_i;
  assign w_full     = (r_count == CNT_W'(els_p));
  // A full queue still accepts a push when its head leaves in the same cycle.
  assign w_push     = w_enq & (~w_full | w_deq);
  assign w_occ      = OCC_W'(r_count) + OCC_W'(r_pending);
  assign w_head     = r_mem[r_rd_ptr];

  assign credit_avail_o = (w_occ < OCC_W'(els_p));
  assign ret_v_o        = (r_count != '0);

  // Head entry onto the return port; zeros while the queue is empty.
  always_comb begin
    ret_type_o   = '0;
    ret_data_o   = '0;
    ret_reg_id_o = '0;
    ret_x_o      = '0;
    ret_y_o      = '0;
    if (ret_v_o) begin
      ret_type_o   = w_head.meta.typ;
      ret_data_o   = w_head.data;
      ret_reg_id_o = w_head.meta.reg_id;
      ret_x_o      = w_head.meta.x;
      ret_y_o      = w_head.meta.y;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pending <= 1'b0;
      r_meta    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_pending <= req_yumi_i;
      if (req_yumi_i) begin
        r_meta.x      <= req_src_x_i;
        r_meta.y      <= req_src_y_i;
        r_meta.reg_id <= req_reg_id_i;
        r_meta.typ    <= w_req_type;
      end
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_deq)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_push, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_push) begin
      r_mem[r_wr_ptr] <= '{meta: r_meta, data: rsp_data_i};
    end
  end

  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(rsp_v_i && !r_pending))
        else $error("rsp_v_i with no pending request metadata; response word dropped");
      assert (!(r_pending && !rsp_v_i))
        else $error("pending request metadata with no response word; metadata dropped");
      assert (!(w_enq && w_full && !w_deq))
        else $error("enqueue into a full return queue");
    end
  end

endmodule

// File: tb/tb_network_rx_return_queue.sv
// Randomized and directed bench for network_rx_return_queue; an ordered packet list
// per instance (depth 2 and depth 3) predicts every output each cycle.
module tb_network_rx_return_queue;

  localparam int unsigned DW  = 32;
  localparam int unsigned XW  = 7;
  localparam int unsigned YW  = 7;
  localparam int unsigned RW  = 5;
  localparam int          LSZ = 1024;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [RW-1:0] rid;
    logic [1:0]    typ;
    logic [DW-1:0] data;
  } pkt_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          yumi  [2];
  logic [XW-1:0] sx    [2];
  logic [YW-1:0] sy    [2];
  logic [RW-1:0] srid  [2];
  logic          sw    [2];
  logic          sf    [2];
  logic          rsp_v [2];
  logic [DW-1:0] rsp_d [2];
  logic          ready [2];
  logic          credit[2];
  logic          rv    [2];
  logic [1:0]    rtype [2];
  logic [DW-1:0] rdata [2];
  logic [RW-1:0] rrid  [2];
  logic [XW-1:0] rx    [2];
  logic [YW-1:0] ry    [2];

  network_rx_return_queue #(.els_p(2)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .req_yumi_i(yumi[0]), .req_src_x_i(sx[0]),
    .req_src_y_i(sy[0]), .req_reg_id_i(srid[0]), .req_w_i(sw[0]), .req_float_wb_i(sf[0]),
    .rsp_v_i(rsp_v[0]), .rsp_data_i(rsp_d[0]), .credit_avail_o(credit[0]), .ret_v_o(rv[0]),
    .ret_type_o(rtype[0]), .ret_data_o(rdata[0]), .ret_reg_id_o(rrid[0]), .ret_x_o(rx[0]),
    .ret_y_o(ry[0]), .ret_ready_i(ready[0])
  );

  network_rx_return_queue #(.els_p(3)) u_dut3 (
    .clk_i(clk), .reset_i(reset), .req_yumi_i(yumi[1]), .req_src_x_i(sx[1]),
    .req_src_y_i(sy[1]), .req_reg_id_i(srid[1]), .req_w_i(sw[1]), .req_float_wb_i(sf[1]),
    .rsp_v_i(rsp_v[1]), .rsp_data_i(rsp_d[1]), .credit_avail_o(credit[1]), .ret_v_o(rv[1]),
    .ret_type_o(rtype[1]), .ret_data_o(rdata[1]), .ret_reg_id_o(rrid[1]), .ret_x_o(rx[1]),
    .ret_y_o(ry[1]), .ret_ready_i(ready[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  pkt_t mlist [2][LSZ];
  int   mh [2];
  int   mt [2];
  logic mpend [2];
  pkt_t mmeta [2];
  int   dut_pops [2];
  int   issued [2];
  bit   started = 1'b0;

  function automatic int els_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic bit model_credit(input int k);
    return ((mt[k] - mh[k]) + int'(mpend[k])) < els_of(k);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: ordered list of packets; pop the head on ready, append on paired response.
  always @(posedge clk) begin
    started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mh[k] = 0; mt[k] = 0; mpend[k] = 1'b0; mmeta[k] = '0;
      end else begin
        if ((mt[k] - mh[k]) > 0 && ready[k]) mh[k]++;
        if (rsp_v[k] && mpend[k]) begin
          mlist[k][mt[k] % LSZ] = mmeta[k];
          mlist[k][mt[k] % LSZ].data = rsp_d[k];
          mt[k]++;
        end
        mpend[k] = yumi[k];
        if (yumi[k]) begin
          mmeta[k].x    = sx[k];
          mmeta[k].y    = sy[k];
          mmeta[k].rid  = srid[k];
          mmeta[k].typ  = sw[k] ? 2'd0 : (sf[k] ? 2'd2 : 2'd1);
          mmeta[k].data = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        int   cnt;
        pkt_t act;
        cnt = mt[k] - mh[k];
        chk($sformatf("ret_v[%0d]", k), 64'(rv[k]), 64'(cnt != 0));
        chk($sformatf("credit[%0d]", k), 64'(credit[k]), 64'(model_credit(k)));
        if (cnt != 0) begin
          act = '{x: rx[k], y: ry[k], rid: rrid[k], typ: rtype[k], data: rdata[k]};
          chk($sformatf("ret_pkt[%0d]", k), 64'(act), 64'(mlist[k][mh[k] % LSZ]));
        end
      end
    end
  end

  task automatic next_cycle();
    for (int k = 0; k < 2; k++) if (rv[k] && ready[k]) dut_pops[k]++;
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [XW-1:0] x,
                         input logic [YW-1:0] y, input logic [RW-1:0] r,
                         input logic wv, input logic fv);
    yumi[k] = v; sx[k] = x; sy[k] = y; srid[k] = r; sw[k] = wv; sf[k] = fv;
  endtask

  task automatic set_rsp(input int k, input logic v, input logic [DW-1:0] d);
    rsp_v[k] = v; rsp_d[k] = d;
  endtask

  task automatic chk_zero_port(input int k);
    chk("rst_ret_v", 64'(rv[k]), 64'd0);
    chk("rst_credit", 64'(credit[k]), 64'd1);
    chk("rst_fields", {rx[k], ry[k], rrid[k], rtype[k], rdata[k]}, 64'd0);
  endtask

  initial begin
    logic prev_y [2];
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_req(k, 0, '0, '0, '0, 0, 0); set_rsp(k, 0, '0); ready[k] = 1'b1;
      dut_pops[k] = 0; issued[k] = 0; mh[k] = 0; mt[k] = 0; mpend[k] = 1'b0;
    end
    repeat (3) next_cycle();
    chk_zero_port(0);
    chk_zero_port(1);
    reset = 1'b0;
    next_cycle();

    // Load returns int writeback two cycles after acceptance.
    set_req(0, 1, 7'd3, 7'd2, 5'd7, 0, 0); next_cycle();
    set_req(0, 0, '0, '0, '0, 0, 0); set_rsp(0, 1, 32'hCAFE0001); next_cycle();
    set_rsp(0, 0, '0);
    chk("t1_v", 64'(rv[0]), 64'd1);
    chk("t1_type", 64'(rtype[0]), 64'd1);
    chk("t1_data", 64'(rdata[0]), 64'hCAFE0001);
    chk("t1_xyr", {rx[0], ry[0], rrid[0]}, {45'd0, 7'd3, 7'd2, 5'd7});
    next_cycle();
    chk("t1_popped", 64'(rv[0]), 64'd0);

    // Store ignores float_wb and returns a credit.
    set_req(0, 1, 7'd5, 7'd1, 5'd9, 1, 1); next_cycle();
    set_req(0, 0, '0, '0, '0, 0, 0); set_rsp(0, 1, 32'h0); next_cycle();
    set_rsp(0, 0, '0);
    chk("t2_type", 64'(rtype[0]), 64'd0);
    chk("t2_data", 64'(rdata[0]), 64'd0);
    next_cycle();

    // Stall fills the depth-2 queue; head holds, then drains in order.
    ready[0] = 1'b0;
    set_req(0, 1, 7'd1, 7'd0, 5'd1, 0, 0); next_cycle();
    set_req(0, 1, 7'd2, 7'd0, 5'd2, 0, 1); set_rsp(0, 1, 32'h11); next_cycle();
    set_req(0, 0, '0, '0, '0, 0, 0); set_rsp(0, 1, 32'h22); next_cycle();
    set_rsp(0, 0, '0);
    chk("t3_credit_full", 64'(credit[0]), 64'd0);
    repeat (3) next_cycle();
    chk("t3_head_hold", {rx[0], rdata[0]}, {25'd0, 7'd1, 32'h11});
    ready[0] = 1'b1; next_cycle();
    chk("t3_credit_back", 64'(credit[0]), 64'd1);
    chk("t3_second", {rx[0], rtype[0], rdata[0]}, {23'd0, 7'd2, 2'd2, 32'h22});
    next_cycle();
    chk("t3_empty", 64'(rv[0]), 64'd0);

    // Push into a full queue while the head leaves.
    ready[0] = 1'b0;
    set_req(0, 1, 7'd10, 7'd0, 5'd0, 0, 0); next_cycle();
    set_req(0, 1, 7'd11, 7'd0, 5'd0, 0, 0); set_rsp(0, 1, 32'hA); next_cycle();
    set_req(0, 0, '0, '0, '0, 0, 0); set_rsp(0, 1, 32'hB); next_cycle();
    set_req(0, 1, 7'd12, 7'd0, 5'd0, 0, 0); set_rsp(0, 0, '0); next_cycle();
    set_req(0, 0, '0, '0, '0, 0, 0); set_rsp(0, 1, 32'hC); ready[0] = 1'b1; next_cycle();
    set_rsp(0, 0, '0);
    chk("t4_head_b", {rx[0], rdata[0]}, {25'd0, 7'd11, 32'hB});
    chk("t4_still_full", 64'(credit[0]), 64'd0);
    next_cycle();
    chk("t4_head_c", {rx[0], rdata[0]}, {25'd0, 7'd12, 32'hC});
    next_cycle();
    chk("t4_empty", 64'(rv[0]), 64'd0);

    // Random streaming on both depths under random backpressure.
    for (int k = 0; k < 2; k++) begin
      dut_pops[k] = 0; issued[k] = 0; prev_y[k] = 1'b0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        set_rsp(k, prev_y[k], $urandom);
        ready[k] = ($urandom_range(0, 3) != 0);
        yumi[k]  = model_credit(k) && ($urandom_range(0, 3) != 0);
        sx[k] = XW'($urandom); sy[k] = YW'($urandom); srid[k] = RW'($urandom);
        sw[k] = 1'($urandom); sf[k] = 1'($urandom);
        if (yumi[k]) issued[k]++;
        prev_y[k] = yumi[k];
      end
      next_cycle();
    end
    for (int k = 0; k < 2; k++) begin
      yumi[k] = 1'b0; set_rsp(k, prev_y[k], $urandom); ready[k] = 1'b1;
    end
    next_cycle();
    for (int k = 0; k < 2; k++) set_rsp(k, 0, '0);
    repeat (8) next_cycle();
    chk("t5_delivered_d2", 64'(dut_pops[0]), 64'(issued[0]));
    chk("t5_delivered_d3", 64'(dut_pops[1]), 64'(issued[1]));
    chk("t5_drained_d3", 64'(rv[1]), 64'd0);

    // Reset with a full queue and pending metadata discards everything.
    ready[0] = 1'b0;
    set_req(0, 1, 7'd20, 7'd0, 5'd0, 0, 0); next_cycle();
    set_req(0, 1, 7'd21, 7'd0, 5'd0, 0, 0); set_rsp(0, 1, 32'h1); next_cycle();
    set_req(0, 0, '0, '0, '0, 0, 0); set_rsp(0, 1, 32'h2); next_cycle();
    set_req(0, 1, 7'd22, 7'd0, 5'd0, 0, 0); set_rsp(0, 0, '0); next_cycle();
    set_req(0, 0, '0, '0, '0, 0, 0); reset = 1'b1; next_cycle();
    chk_zero_port(0);
    reset = 1'b0; ready[0] = 1'b1; next_cycle();
    set_req(0, 1, 7'd4, 7'd3, 5'd2, 0, 0); next_cycle();
    set_req(0, 0, '0, '0, '0, 0, 0); set_rsp(0, 1, 32'h5); next_cycle();
    set_rsp(0, 0, '0);
    chk("t6_recover", {rv[0], rx[0], ry[0], rdata[0]}, {17'd0, 1'b1, 7'd4, 7'd3, 32'h5});
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
